// File: rtl/hazard_control_unit_if.sv
// ============================================================================
// hazard_control_unit_if : pipeline hazard sideband bundle (ID/EX/MEM/WB
// register tags in, stage enables / forwarding selects / perf counters out)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ID_Rn, ID_Rm, ID_Rs;
  logic             ID_Use_Rn, ID_Use_Rm, ID_Use_Rs;
  logic [3:0]       EX_Rd;
  logic             EX_rf, EX_Load;
  logic [3:0]       MEM_Rd;
  logic             MEM_rf;
  logic [3:0]       WB_Rd;
  logic             WB_rf;
  logic             Branch_Taken;
  logic             Mem_Busy;
  logic [1:0]       Fwd_A, Fwd_B, Fwd_C;
  logic             PC_LE, IFID_LE, IDEX_LE, EXMEM_LE;
  logic             IFID_CLR, IDEX_CLR;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;
  logic             Mem_Timeout;

  modport master (
    output ID_Rn, ID_Rm, ID_Rs, ID_Use_Rn, ID_Use_Rm, ID_Use_Rs,
    output EX_Rd, EX_rf, EX_Load, MEM_Rd, MEM_rf, WB_Rd, WB_rf,
    output Branch_Taken, Mem_Busy,
    input  Fwd_A, Fwd_B, Fwd_C, PC_LE, IFID_LE, IDEX_LE, EXMEM_LE,
    input  IFID_CLR, IDEX_CLR, Stall_Count, Flush_Count, Mem_Timeout
  );

  modport slave (
    input  ID_Rn, ID_Rm, ID_Rs, ID_Use_Rn, ID_Use_Rm, ID_Use_Rs,
    input  EX_Rd, EX_rf, EX_Load, MEM_Rd, MEM_rf, WB_Rd, WB_rf,
    input  Branch_Taken, Mem_Busy,
    output Fwd_A, Fwd_B, Fwd_C, PC_LE, IFID_LE, IDEX_LE, EXMEM_LE,
    output IFID_CLR, IDEX_CLR, Stall_Count, Flush_Count, Mem_Timeout
  );
endinterface

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit : five-stage pipeline sequencer (load-use stall, branch
// flush, memory-wait freeze, operand forwarding, perf counters)
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  wire logic          CLK,
  input  wire logic          CLR,
  hazard_control_unit_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_t;

  localparam logic [7:0] c_wait_max = 8'(MAX_WAIT);

  state_t           r_state, w_next;
  logic [7:0]       r_wait_cnt, w_wait_next;
  logic             r_timeout, w_set_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_pc_le, w_ifid_le, w_idex_le, w_exmem_le;
  logic             w_ifid_clr, w_idex_clr;
  logic             w_load_use;
  logic [1:0]       w_fwd_a, w_fwd_b, w_fwd_c;

  // R15 is the PC and never comes from a pipeline register
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] s, input logic u,
    input logic [3:0] ex_rd, input logic ex_ok,
    input logic [3:0] mem_rd, input logic mem_rf,
    input logic [3:0] wb_rd, input logic wb_rf);
    if (!u || s == 4'hF)             return 2'b00;
    else if (ex_ok && ex_rd == s)    return 2'b01;
    else if (mem_rf && mem_rd == s)  return 2'b10;
    else if (wb_rf && wb_rd == s)    return 2'b11;
    else                             return 2'b00;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(hz.ID_Rn, hz.ID_Use_Rn, hz.EX_Rd, hz.EX_rf & ~hz.EX_Load,
                      hz.MEM_Rd, hz.MEM_rf, hz.WB_Rd, hz.WB_rf);
    w_fwd_b = fwd_sel(hz.ID_Rm, hz.ID_Use_Rm, hz.EX_Rd, hz.EX_rf & ~hz.EX_Load,
                      hz.MEM_Rd, hz.MEM_rf, hz.WB_Rd, hz.WB_rf);
    w_fwd_c = fwd_sel(hz.ID_Rs, hz.ID_Use_Rs, hz.EX_Rd, hz.EX_rf & ~hz.EX_Load,
                      hz.MEM_Rd, hz.MEM_rf, hz.WB_Rd, hz.WB_rf);
  end

  assign w_load_use = hz.EX_Load & hz.EX_rf &
      ((hz.ID_Use_Rn & (hz.ID_Rn != 4'hF) & (hz.ID_Rn == hz.EX_Rd)) |
       (hz.ID_Use_Rm & (hz.ID_Rm != 4'hF) & (hz.ID_Rm == hz.EX_Rd)) |
       (hz.ID_Use_Rs & (hz.ID_Rs != 4'hF) & (hz.ID_Rs == hz.EX_Rd)));

  always_comb begin
    w_next        = r_state;
    w_wait_next   = r_wait_cnt;
    w_set_timeout = 1'b0;
    w_pc_le       = 1'b1;
    w_ifid_le     = 1'b1;
    w_idex_le     = 1'b1;
    w_exmem_le    = 1'b1;
    w_ifid_clr    = 1'b0;
    w_idex_clr    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hz.Mem_Busy) begin
          {w_pc_le, w_ifid_le, w_idex_le, w_exmem_le} = 4'b0000;
          w_next      = ST_MEMWAIT;
          w_wait_next = 8'd1;
        end else if (w_load_use) begin
          w_pc_le    = 1'b0;
          w_ifid_le  = 1'b0;
          w_idex_clr = 1'b1;
        end else if (hz.Branch_Taken) begin
          w_ifid_clr = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (hz.Mem_Busy) begin
          {w_pc_le, w_ifid_le, w_idex_le, w_exmem_le} = 4'b0000;
          w_wait_next   = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
          w_set_timeout = (r_wait_cnt >= c_wait_max);
        end else begin
          w_next      = ST_RUN;
          w_wait_next = 8'd0;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_set_timeout)
        r_timeout <= 1'b1;
      if (!w_pc_le && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((w_ifid_clr || w_idex_clr) && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Reset overrides the stage controls combinationally so the pipe is held empty
  assign hz.PC_LE       = CLR & w_pc_le;
  assign hz.IFID_LE     = CLR & w_ifid_le;
  assign hz.IDEX_LE     = CLR & w_idex_le;
  assign hz.EXMEM_LE    = CLR & w_exmem_le;
  assign hz.IFID_CLR    = ~CLR | w_ifid_clr;
  assign hz.IDEX_CLR    = ~CLR | w_idex_clr;
  assign hz.Fwd_A       = CLR ? w_fwd_a : 2'b00;
  assign hz.Fwd_B       = CLR ? w_fwd_b : 2'b00;
  assign hz.Fwd_C       = CLR ? w_fwd_c : 2'b00;
  assign hz.Stall_Count = r_stall_cnt;
  assign hz.Flush_Count = r_flush_cnt;
  assign hz.Mem_Timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// tb_hazard_control_unit : vector table plus hand-written multi-cycle sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  localparam int CNT_W = 4;

  logic CLK;
  logic CLR;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_control_unit #(.CNT_W(CNT_W), .MAX_WAIT(15)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .hz  (hz.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // fwd = {A,B,C}; le = {PC,IFID,IDEX,EXMEM}; clr = {IFID,IDEX}
  typedef struct packed {
    logic [5:0] fwd;
    logic [3:0] le;
    logic [1:0] clr;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] rn, rm, rs;
    logic [2:0] use3;
    logic [3:0] ex_rd;
    logic       ex_rf, ex_ld;
    logic [3:0] mem_rd;
    logic       mem_rf;
    logic [3:0] wb_rd;
    logic       wb_rf;
    logic       br, busy;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string n, logic [3:0] rn, rm, rs, logic [2:0] use3,
                              logic [3:0] ex_rd, logic ex_rf, ex_ld,
                              logic [3:0] mem_rd, logic mem_rf,
                              logic [3:0] wb_rd, logic wb_rf, logic br, busy,
                              logic [5:0] fwd, logic [3:0] le, logic [1:0] clr);
    vec_t v;
    v.name = n; v.rn = rn; v.rm = rm; v.rs = rs; v.use3 = use3;
    v.ex_rd = ex_rd; v.ex_rf = ex_rf; v.ex_ld = ex_ld;
    v.mem_rd = mem_rd; v.mem_rf = mem_rf; v.wb_rd = wb_rd; v.wb_rf = wb_rf;
    v.br = br; v.busy = busy;
    v.e.fwd = fwd; v.e.le = le; v.e.clr = clr;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic set_in(vec_t v);
    hz.ID_Rn = v.rn; hz.ID_Rm = v.rm; hz.ID_Rs = v.rs;
    {hz.ID_Use_Rn, hz.ID_Use_Rm, hz.ID_Use_Rs} = v.use3;
    hz.EX_Rd = v.ex_rd; hz.EX_rf = v.ex_rf; hz.EX_Load = v.ex_ld;
    hz.MEM_Rd = v.mem_rd; hz.MEM_rf = v.mem_rf;
    hz.WB_Rd = v.wb_rd; hz.WB_rf = v.wb_rf;
    hz.Branch_Taken = v.br; hz.Mem_Busy = v.busy;
  endtask

  task automatic check_out(string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_fwd"}, 32'({hz.Fwd_A, hz.Fwd_B, hz.Fwd_C}), 32'(e.fwd));
    chk({nm, "_le"},  32'({hz.PC_LE, hz.IFID_LE, hz.IDEX_LE, hz.EXMEM_LE}), 32'(e.le));
    chk({nm, "_clr"}, 32'({hz.IFID_CLR, hz.IDEX_CLR}), 32'(e.clr));
  endtask

  // drive inputs, queue the expectation, compare before the next rising edge
  task automatic apply(vec_t v);
    set_in(v);
    sb.push_back(v.e);
    #2;
    check_out(v.name);
  endtask

  task automatic drive(vec_t v);
    @(negedge CLK);
    apply(v);
  endtask

  vec_t idle;

  task automatic do_reset();
    set_in(idle);
    CLR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    idle = mk("idle", 15,15,15,3'b000, 0,0,0, 0,0, 0,0, 0,0, 6'b0, 4'hF, 2'b00);

    tbl[0]  = idle;
    tbl[1]  = mk("fwd_ex_pri",  3,15,15,3'b100,  3,1,0,  3,1,  0,0, 0,0, 6'b01_00_00, 4'hF, 2'b00);
    tbl[2]  = mk("fwd_r15",    15,15,15,3'b100, 15,1,0, 15,1, 15,1, 0,0, 6'b00_00_00, 4'hF, 2'b00);
    tbl[3]  = mk("fwd_mem_pri",15, 5,15,3'b010,  0,0,0,  5,1,  5,1, 0,0, 6'b00_10_00, 4'hF, 2'b00);
    tbl[4]  = mk("fwd_wb",     15,15, 7,3'b001,  0,0,0,  0,0,  7,1, 0,0, 6'b00_00_11, 4'hF, 2'b00);
    tbl[5]  = mk("fwd_unused",  4, 4, 4,3'b000,  4,1,0,  4,1,  4,1, 0,0, 6'b00_00_00, 4'hF, 2'b00);
    tbl[6]  = mk("fwd_mix",     2, 9,11,3'b111,  2,1,0,  9,1, 11,1, 0,0, 6'b01_10_11, 4'hF, 2'b00);
    tbl[7]  = mk("ld_unused",   8, 6,15,3'b100,  6,1,1,  8,1,  0,0, 0,0, 6'b10_00_00, 4'hF, 2'b00);
    tbl[8]  = mk("ld_norf",     6,15,15,3'b100,  6,0,1,  0,0,  0,0, 0,0, 6'b00_00_00, 4'hF, 2'b00);
    tbl[9]  = mk("ld_use",     15, 2,15,3'b010,  2,1,1,  0,0,  2,1, 0,0, 6'b00_11_00, 4'h3, 2'b01);
    tbl[10] = mk("ld_r15",     15,15,15,3'b111, 15,1,1,  0,0,  0,0, 0,0, 6'b00_00_00, 4'hF, 2'b00);
    tbl[11] = mk("branch",     15,15,15,3'b000,  0,0,0,  0,0,  0,0, 1,0, 6'b00_00_00, 4'hF, 2'b10);
    tbl[12] = mk("br_ld",      15,15, 1,3'b001,  1,1,1,  0,0,  0,0, 1,0, 6'b00_00_00, 4'h3, 2'b01);

    // reset holds the pipe even with a forwardable operand present
    CLR = 1'b0;
    v = mk("rst", 3,15,15,3'b100, 3,1,0, 3,1, 0,0, 1,0, 6'b0, 4'h0, 2'b11);
    drive(v);
    drive(v);
    chk("rst_stall_cnt", 32'(hz.Stall_Count), 32'd0);
    chk("rst_flush_cnt", 32'(hz.Flush_Count), 32'd0);
    chk("rst_timeout",   32'(hz.Mem_Timeout), 32'd0);
    CLR = 1'b1;
    v = idle; v.name = "rst_release";
    apply(v);

    for (int i = 0; i < 13; i++) drive(tbl[i]);

    // load-use: one bubble, then the load is forwarded from MEM
    do_reset();
    drive(tbl[9]);
    drive(mk("ld_in_mem", 15,2,15,3'b010, 0,0,0, 2,1, 0,0, 0,0, 6'b00_10_00, 4'hF, 2'b00));
    chk("lu_stall_cnt", 32'(hz.Stall_Count), 32'd1);
    chk("lu_flush_cnt", 32'(hz.Flush_Count), 32'd1);

    // branch suppressed by load-use, honoured on the following cycle
    drive(tbl[12]);
    drive(mk("br_retry", 15,15,1,3'b001, 0,0,0, 1,1, 0,0, 1,0, 6'b00_00_10, 4'hF, 2'b10));

    // long memory wait with hazards present that must be ignored
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      drive(mk("memwait", 15,15,1,3'b001, 1,1,1, 0,0, 0,0, (k > 1), 1,
               6'b00_00_00, 4'h0, 2'b00));
      if (k == 15) begin
        chk("mw_stall_cnt14", 32'(hz.Stall_Count), 32'd14);
        chk("mw_timeout_early", 32'(hz.Mem_Timeout), 32'd0);
      end
    end
    v = idle; v.name = "mem_release";
    drive(v);
    chk("mw_timeout_set", 32'(hz.Mem_Timeout), 32'd1);
    chk("mw_stall_sat",   32'(hz.Stall_Count), 32'd15);
    chk("mw_flush_zero",  32'(hz.Flush_Count), 32'd0);
    v = idle; v.name = "after_release";
    drive(v);
    chk("mw_timeout_sticky", 32'(hz.Mem_Timeout), 32'd1);

    // reset while waiting on memory returns straight to RUN
    v = mk("mw2", 15,15,15,3'b000, 0,0,0, 0,0, 0,0, 0,1, 6'b0, 4'h0, 2'b00);
    drive(v);
    drive(v);
    CLR = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    v = tbl[11]; v.name = "rst_midwait_run";
    apply(v);
    chk("rmw_stall_cnt", 32'(hz.Stall_Count), 32'd0);
    chk("rmw_flush_cnt", 32'(hz.Flush_Count), 32'd0);
    chk("rmw_timeout",   32'(hz.Mem_Timeout), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
